// File: rtl/cpu_pkg.sv
// Shared CPU definitions: PC type and fetch-related constants used by fetch,
// control and the EX datapath.
package cpu_pkg;

  typedef logic [31:0] pc_t;

  localparam pc_t         RESET_PC  = 32'h0000_0000;
  localparam int          IMEM_AW   = 12;
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage boundary: redirect/hold from EX, instruction-memory bus, and the
// PC/instruction handed to EX.
interface fetch_stage_if #(parameter int IMEM_AW = cpu_pkg::IMEM_AW);
  import cpu_pkg::*;

  logic               hold;
  logic               redirect_valid;
  pc_t                redirect_pc;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_rdata;
  pc_t                pc_EX;
  logic [31:0]        instr_EX;
  logic               stall_EX;

  modport master (
    input  hold, redirect_valid, redirect_pc, imem_rdata,
    output imem_addr, pc_EX, instr_EX, stall_EX
  );

  modport slave (
    output hold, redirect_valid, redirect_pc, imem_rdata,
    input  imem_addr, pc_EX, instr_EX, stall_EX
  );

endinterface

// File: rtl/fetch_stage_pc_next.sv
// Next-state select for the fetch PC pair and squash flag:
// hold beats redirect beats sequential +4.
module pc_next
  import cpu_pkg::*;
(
  input  logic hold,
  input  logic redirect_valid,
  input  logic stall_q,
  input  pc_t  redirect_pc,
  input  pc_t  pc_f,
  input  pc_t  pc_ex,
  output pc_t  pc_f_nxt,
  output pc_t  pc_ex_nxt,
  output logic stall_nxt
);

  logic redir;

  // a squashed instruction in EX is wrong-path, so its redirect is meaningless
  assign redir = redirect_valid & ~stall_q & ~hold;

  always_comb begin
    pc_f_nxt  = pc_f + 32'd4;
    pc_ex_nxt = pc_f;
    stall_nxt = 1'b0;
    if (hold) begin
      pc_f_nxt  = pc_f;
      pc_ex_nxt = pc_ex;
      stall_nxt = stall_q;
    end else if (redir) begin
      pc_f_nxt  = redirect_pc & ~32'h3;
      stall_nxt = 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// Fetch stage: PC register, synchronous imem addressing and the EX pipeline
// register. Define FETCH_PERF_EN to add the bubble_cnt performance counter.
module fetch_stage #(
  parameter cpu_pkg::pc_t RESET_PC  = cpu_pkg::RESET_PC,
  parameter int           IMEM_AW   = cpu_pkg::IMEM_AW,
  parameter logic [31:0]  NOP_INSTR = cpu_pkg::NOP_INSTR
) (
  input  logic         clk,
  input  logic         rst,
  fetch_stage_if.master fif
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0]  bubble_cnt
`endif
);
  import cpu_pkg::*;

  pc_t  pc_f, pc_ex;
  logic stall_q;
  pc_t  pc_f_nxt, pc_ex_nxt;
  logic stall_nxt;

  pc_next u_pc_next (
    .hold           (fif.hold),
    .redirect_valid (fif.redirect_valid),
    .stall_q        (stall_q),
    .redirect_pc    (fif.redirect_pc),
    .pc_f           (pc_f),
    .pc_ex          (pc_ex),
    .pc_f_nxt       (pc_f_nxt),
    .pc_ex_nxt      (pc_ex_nxt),
    .stall_nxt      (stall_nxt)
  );

  // memory data is not valid in the first cycle out of reset, hence the bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_f    <= RESET_PC;
      pc_ex   <= RESET_PC;
      stall_q <= 1'b1;
    end else begin
      pc_f    <= pc_f_nxt;
      pc_ex   <= pc_ex_nxt;
      stall_q <= stall_nxt;
    end
  end

  // re-reading pc_EX while held keeps imem_rdata stable once hold drops
  assign fif.imem_addr = fif.hold ? pc_ex[IMEM_AW+1:2] : pc_f[IMEM_AW+1:2];
  assign fif.pc_EX     = pc_ex;
  assign fif.stall_EX  = stall_q;
  assign fif.instr_EX  = stall_q ? NOP_INSTR : fif.imem_rdata;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bubble_cnt <= 32'd0;
    end else if (stall_q && !fif.hold) begin
      bubble_cnt <= bubble_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed per-cycle vectors push the
// expected EX state, a negedge monitor pops and compares.
module tb_fetch_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct packed {
    logic        stall;
    logic [31:0] pc;
    logic        chk_addr;
    logic [11:0] addr;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

`ifdef FETCH_PERF_EN
  logic [31:0] bubble_cnt;
`endif

  fetch_stage_if #(.IMEM_AW(12)) fif ();

  fetch_stage dut (
    .clk (clk),
    .rst (rst),
    .fif (fif)
`ifdef FETCH_PERF_EN
    ,
    .bubble_cnt (bubble_cnt)
`endif
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return {a, 8'hA5, a};
  endfunction

  always @(posedge clk) fif.imem_rdata <= mem_word(fif.imem_addr);

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        exp_t e;
        e = sb.pop_front();
        check32("stall_EX", {31'd0, fif.stall_EX}, {31'd0, e.stall});
        check32("pc_EX", fif.pc_EX, e.pc);
        check32("instr_EX", fif.instr_EX, e.stall ? NOP : mem_word(e.pc[13:2]));
        if (e.chk_addr)
          check32("imem_addr", {20'd0, fif.imem_addr}, {20'd0, e.addr});
      end
    end
  end

  task automatic step(input logic h, input logic rv, input logic [31:0] rpc,
                      input logic es, input logic [31:0] epc,
                      input logic ca, input logic [11:0] ea);
    exp_t e;
    e.stall    = es;
    e.pc       = epc;
    e.chk_addr = ca;
    e.addr     = ea;
    sb.push_back(e);
    fif.hold           = h;
    fif.redirect_valid = rv;
    fif.redirect_pc    = rpc;
    @(posedge clk);
    #1;
  endtask

  initial begin
    fif.hold           = 1'b0;
    fif.redirect_valid = 1'b0;
    fif.redirect_pc    = 32'd0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    //    hold rv  rpc           stall pc_EX         chk addr
    step(0, 0, 32'h0,          1, 32'h0,          1, 12'h0);
    step(0, 0, 32'h0,          0, 32'h0,          0, 12'h0);
    step(0, 0, 32'h0,          0, 32'h4,          0, 12'h0);
    step(0, 1, 32'h40,         0, 32'h8,          0, 12'h0);
    step(0, 0, 32'h0,          1, 32'hC,          0, 12'h0);
    step(0, 0, 32'h0,          0, 32'h40,         0, 12'h0);
    // back-to-back: second redirect lands on the bubble and is dropped
    step(0, 1, 32'h40,         0, 32'h44,         0, 12'h0);
    step(0, 1, 32'h80,         1, 32'h48,         0, 12'h0);
    step(0, 0, 32'h0,          0, 32'h40,         0, 12'h0);
    step(0, 0, 32'h0,          0, 32'h44,         0, 12'h0);
    step(0, 1, 32'h10,         0, 32'h48,         0, 12'h0);
    step(0, 0, 32'h0,          1, 32'h4C,         0, 12'h0);
`ifdef FETCH_PERF_EN
    check32("bubble_cnt_after_3_redirects", bubble_cnt, 32'd4);
`endif
    // hold for 3 cycles with a redirect pulse that must be ignored
    step(1, 0, 32'h0,          0, 32'h10,         1, 12'h4);
    step(1, 1, 32'h80,         0, 32'h10,         1, 12'h4);
    step(1, 0, 32'h0,          0, 32'h10,         1, 12'h4);
    step(0, 0, 32'h0,          0, 32'h10,         1, 12'h5);
    step(0, 1, 32'h43,         0, 32'h14,         0, 12'h0);
    step(0, 0, 32'h0,          1, 32'h18,         0, 12'h0);
    // wrap past the top of the address space
    step(0, 1, 32'hFFFF_FFFC,  0, 32'h40,         0, 12'h0);
    step(0, 0, 32'h0,          1, 32'h44,         1, 12'hFFF);
    step(0, 0, 32'h0,          0, 32'hFFFF_FFFC,  0, 12'h0);
    // redirect to the PC already being fetched still costs one bubble
    step(0, 1, 32'h4,          0, 32'h0,          1, 12'h1);
    step(0, 0, 32'h0,          1, 32'h4,          0, 12'h0);
    step(0, 0, 32'h0,          0, 32'h4,          0, 12'h0);

`ifdef FETCH_PERF_EN
    check32("bubble_cnt_before_reset", bubble_cnt, 32'd7);
`endif
    #1 rst = 1'b1;
    #1;
    check32("rst_async_stall_EX", {31'd0, fif.stall_EX}, 32'd1);
    check32("rst_async_pc_EX", fif.pc_EX, 32'h0);
    check32("rst_async_instr_EX", fif.instr_EX, NOP);
    check32("rst_async_imem_addr", {20'd0, fif.imem_addr}, 32'd0);
`ifdef FETCH_PERF_EN
    check32("rst_async_bubble_cnt", bubble_cnt, 32'd0);
`endif
    #1 rst = 1'b0;

    step(0, 0, 32'h0,          1, 32'h0,          1, 12'h0);
    step(0, 0, 32'h0,          0, 32'h0,          0, 12'h0);
    step(0, 0, 32'h0,          0, 32'h4,          0, 12'h0);

    #10;
    check32("scoreboard_drained", sb.size(), 32'd0);
`ifdef FETCH_PERF_EN
    check32("bubble_cnt_after_restart", bubble_cnt, 32'd1);
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Fetch stage of the 3-stage RV32 pipeline (FETCH -> EX -> WB); sits directly upstream of the EX-stage control/decode.
- Holds the PC, drives the synchronous instruction memory, and registers the fetched PC and instruction into EX.
- Takes branch/jump redirects from EX and generates `stall_EX`, which squashes the wrong-path instruction in EX.

Parameters:
- `RESET_PC`, `32'h0000_0000`, PC value loaded on reset.
- `IMEM_AW`, 12, instruction-memory word-address width (4096 words).
- `NOP_INSTR`, `32'h0000_0013`, encoding presented on `instr_EX` while squashed (addi x0,x0,0).

Ports:
- `clk`  in  1  system clock; all state updates on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `hold`  in  1  freeze request from downstream; pipeline holds while 1.
- `redirect_valid`  in  1  EX resolved a taken branch, jal or jalr this cycle.
- `redirect_pc`  in  32  target byte address from EX.
- `imem_addr`  out  IMEM_AW  word address to instruction memory; registered read, data returns next cycle.
- `imem_rdata`  in  32  instruction-memory read data for the address presented last cycle.
- `pc_EX`  out  32  byte PC of the instruction currently in EX.
- `instr_EX`  out  32  instruction currently in EX.
- `stall_EX`  out  1  1 = EX instruction is a bubble/wrong-path; feeds control stall input.

Behaviour:
- State registers:
  - `pc_F` (32): address being fetched.
  - `pc_EX` (32).
  - `stall_q` (1).
- Reset (async, immediate):
  - `pc_F` = RESET_PC.
  - `pc_EX` = RESET_PC.
  - `stall_q` = 1, so the first EX cycle is a bubble because memory data is not yet valid.
- Outputs:
  - `stall_EX` = `stall_q`.
  - `instr_EX` = `stall_q` ? NOP_INSTR : `imem_rdata`.
  - `imem_addr` = `hold` ? `pc_EX[IMEM_AW+1:2]` : `pc_F[IMEM_AW+1:2]`. Re-reading `pc_EX` during hold keeps `imem_rdata` stable for the next cycle.
- Effective redirect: `redir` = `redirect_valid` & ~`stall_q` & ~`hold`. A squashed instruction can never redirect.
- Next-state priority, highest first:
  1. `hold`: `pc_F`, `pc_EX` and `stall_q` all keep their values; any redirect is ignored, and EX re-asserts it after hold drops.
  2. `redir`: `pc_F` <= {`redirect_pc[31:2]`, 2'b00}; `pc_EX` <= `pc_F`; `stall_q` <= 1, which squashes the sequential instruction fetched this cycle.
  3. Default: `pc_F` <= `pc_F` + 4 (mod 2^32, wraps to 0 after `32'hFFFF_FFFC`); `pc_EX` <= `pc_F`; `stall_q` <= 0.
- Latency:
  - Redirect target appears in EX two cycles after `redirect_valid`.
  - Exactly one bubble per taken redirect.
- Redirect to the current `pc_F` value is legal; it still produces one bubble.
- Low two bits of `redirect_pc` are discarded; no misalignment trap.
- Redirect asserted on the same cycle as a bubble (`stall_q` = 1) is dropped.
- Reset asserted mid-operation: state returns to reset values the same cycle; the next fetch after deassertion is RESET_PC.

Optional Feature:
- `FETCH_PERF_EN` defined:
  - Adds output `bubble_cnt` (32): counts cycles with `stall_q` = 1 and `hold` = 0.
  - Reset 0; wraps at 2^32.
- `FETCH_PERF_EN` undefined: port and counter absent; all other behaviour identical.

Decomposition:
- Shared package `cpu_pkg`: `NOP_INSTR`, `RESET_PC` default, `IMEM_AW`, and the `pc_t` (logic [31:0]) typedef. The package is shared with control and the EX datapath.
- One sub-module, `pc_next`: combinational next-PC select covering the hold/redirect/+4 priority and alignment.
- The perf counter stays inline.

Test Plan:
- Reset release, no redirect:
  - Cycle 1 after reset: `stall_EX` = 1, `instr_EX` = `32'h13`.
  - Then `pc_EX` = 0, 4, 8 on successive cycles, with `instr_EX` = memory words 0, 1, 2.
- Redirect to `32'h40` while `pc_EX` = 8:
  - Next cycle: `stall_EX` = 1, `instr_EX` = `32'h13`.
  - Following cycle: `pc_EX` = `32'h40`, `stall_EX` = 0.
- Back-to-back redirect: `redirect_valid` held 2 cycles (`32'h40`, then `32'h80`) -> second ignored (bubble); `pc_EX` reaches `32'h40`, never `32'h80`.
- `hold` = 1 for 3 cycles with `pc_EX` = `32'h10`:
  - `pc_EX` and `instr_EX` stay constant; `imem_addr` = 4.
  - A `redirect_valid` pulse during hold is ignored; sequence resumes at `32'h14`.
- Misaligned redirect `32'h43` -> `pc_EX` = `32'h40`.
- Wrap: `pc_F` = `32'hFFFF_FFFC` -> next `pc_F` = 0.
- `rst` pulsed mid-stream -> outputs return to reset values asynchronously; fetch restarts at RESET_PC.
- With `FETCH_PERF_EN`: 3 redirects plus the reset bubble -> `bubble_cnt` = 4.
